i2c_regbank: RTL and testbench
==============================

// Module: i2c_regbank
// PURPOSE
//  Parametrised register bank that sits behind i2cslave_controller_top on its byte interface.
//  It replaces fixed-map register decoding with the following:
//   - configurable read-only (RO) and read-write (RW) register counts;
//   - an auto-incrementing register pointer;
//   - coherent RO snapshots for multi-byte reads;
//   - shadowed RW writes committed atomically on STOP;
//   - a write-lock key.
// PARAMETERS
//  N_RO      16         number of 8-bit RO registers, addresses 0x00..N_RO-1
//  N_RW      32         number of 8-bit RW registers, addresses RW_BASE..RW_BASE+N_RW-1
//  RW_BASE   8'h40      first RW address; RW_BASE >= N_RO and RW_BASE+N_RW <= LOCK_ADDR
//  LOCK_ADDR 8'hFF      address of the lock register
//  LOCK_KEY  8'hA5      value that unlocks RW writes
//  RW_INIT   {8*N_RW{1'b0}}  reset value of rw_data
// PORTS
//  clk        in   1       system clock
//  rst        in   1       asynchronous active-high reset
//  start      in   1       1-cycle pulse from controller on (repeated) START + address match
//  stop       in   1       1-cycle pulse on STOP
//  data_vld   in   1       1-cycle pulse: write byte on rx_data valid (write) / tx_data consumed (read)
//  r_w        in   1       transfer direction, valid from start pulse: 1 = read
//  rx_data    in   8       byte received from the master
//  tx_data    out  8       byte presented to the controller for the next read
//  stretch_on out  1       asks the controller to hold SCL low while tx_data is not ready
//  ro_data    in   8*N_RO  live RO sources; byte i is register i
//  rw_data    out  8*N_RW  committed RW registers; byte j is register RW_BASE+j
//  commit     out  1       1-cycle pulse when a shadow commit updates rw_data
//  wr_err     out  1       1-cycle pulse on a rejected write
//  unlocked   out  1       lock state, 1 = RW writes accepted
// BEHAVIOUR
//  Reset (async, rst=1):
//   - FSM=IDLE, ptr=0, tx_data=0, stretch_on=0, commit=0, wr_err=0, unlocked=0.
//   - rw_data=RW_INIT, shadow=RW_INIT, dirty=0, snapshot=0.
//   - Reset mid-transfer discards all shadow writes.
//  FSM states: IDLE, PTR, WR, RD.
//   - start & !r_w -> PTR.
//   - start & r_w -> RD, and snapshot <= ro_data in the same cycle.
//   - PTR: data_vld -> ptr <= rx_data; -> WR.
//   - WR: each data_vld writes rx_data at ptr, then ptr <= ptr+1 (8-bit wrap 0xFF->0x00).
//   - RD: each data_vld (byte consumed) increments ptr with wrap.
//   - stop -> IDLE from any state. start in any state re-enters as above (repeated start).
//   - When stop and start arrive in the same cycle, stop is processed first, then start.
//  Write decode in WR:
//   - ptr in RW window and unlocked: shadow[ptr-RW_BASE] <= rx_data; dirty <= 1.
//   - ptr == LOCK_ADDR: unlocked <= (rx_data == LOCK_KEY). The lock register reads back {7'b0, unlocked}.
//   - Otherwise (RO, unmapped, or RW while locked): byte dropped; wr_err pulses for 1 cycle.
//  Commit:
//   - On stop with dirty=1: rw_data <= shadow in one cycle; commit pulses 1 cycle later; dirty <= 0.
//   - Repeated start does not commit. Writes accumulate until STOP.
//   - On stop with dirty=0: no commit.
//   - The shadow always mirrors rw_data outside an open write.
//  Read decode (source for tx_data):
//   - RO window -> snapshot byte.
//   - RW window -> rw_data (committed value, not shadow).
//   - LOCK_ADDR -> {7'b0, unlocked}.
//   - Unmapped -> 8'h00.
//   - The snapshot is frozen for the whole read transfer, so multi-byte values are coherent.
//  Read latency and stretch:
//   - tx_data is registered. It loads 1 cycle after entering RD, and 1 cycle after each data_vld in RD.
//   - stretch_on = 1 from the cycle of start(r_w=1) or data_vld in RD until tx_data is loaded (1 cycle). Else 0.
//   - The controller never samples a stale byte.
//  Pointer persistence:
//   - ptr holds across STOP, so a bare read transfer continues from the last pointer.
//   - ptr resets only on rst.
// TESTING
//  1. Reset with rst=1 mid-write after 3 data bytes.
//     -> rw_data==RW_INIT, unlocked=0, no commit pulse, tx_data=0.
//  2. Locked write: PTR=0x40, data 0x12, STOP.
//     -> wr_err pulses once, rw_data[7:0] unchanged, no commit.
//  3. Unlock then burst write: write LOCK_ADDR=0xA5, STOP; then PTR=0x40, data 0x11,0x22,0x33, STOP.
//     -> rw_data[23:0]==24'h332211 updated in the same cycle, a single commit pulse,
//        and rw_data is unchanged before STOP.
//  4. Repeated start: PTR=0x41, data 0xAB, Sr, read 1 byte.
//     -> read returns the old committed value. 0xAB appears only after STOP.
//  5. Snapshot coherency: ro_data[15:0] changes 0x01FF->0x0200 between 2-byte read bytes from PTR=0x00.
//     -> reads 0xFF,0x01 with stretch_on high for exactly 1 cycle after start and after each data_vld.
//  6. Wrap: PTR=0xFF read of 2 bytes.
//     -> {7'b0,unlocked}, then snapshot[7:0] (ptr wrapped to 0x00). Write of 0x00 to PTR 0x20 (unmapped) -> wr_err.

Source files
------------

// File: rtl/i2c_regbank.sv
// Byte-interface register bank for the I2C slave controller: RO snapshot reads,
// shadowed RW writes committed atomically on STOP, auto-incrementing pointer, write-lock key.
module i2c_regbank #(
    parameter int unsigned        N_RO      = 16,
    parameter int unsigned        N_RW      = 32,
    parameter logic [7:0]         RW_BASE   = 8'h40,
    parameter logic [7:0]         LOCK_ADDR = 8'hFF,
    parameter logic [7:0]         LOCK_KEY  = 8'hA5,
    parameter logic [8*N_RW-1:0]  RW_INIT   = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                data_vld,
    input  logic                r_w,
    input  logic [7:0]          rx_data,
    output logic [7:0]          tx_data,
    output logic                stretch_on,
    input  logic [8*N_RO-1:0]   ro_data,
    output logic [8*N_RW-1:0]   rw_data,
    output logic                commit,
    output logic                wr_err,
    output logic                unlocked
);
    localparam int unsigned RO_IW  = (N_RO > 1) ? $clog2(N_RO) : 1;
    localparam int unsigned RW_IW  = (N_RW > 1) ? $clog2(N_RW) : 1;
    localparam logic [8:0]  RW_END = 9'(RW_BASE) + 9'(N_RW);

    typedef enum logic [1:0] {S_IDLE, S_PTR, S_WR, S_RD} state_t;

    state_t     r_state;
    logic [7:0] r_ptr;
    logic [7:0] r_tx;
    logic       r_load;
    logic       r_commit_pend;
    logic       r_commit;
    logic       r_wr_err;
    logic       r_unlocked;
    logic       r_dirty;
    logic [7:0] r_snap   [N_RO];
    logic [7:0] r_rw     [N_RW];
    logic [7:0] r_shadow [N_RW];

    logic             w_in_ro;
    logic             w_in_rw;
    logic [RO_IW-1:0] w_ro_idx;
    logic [RW_IW-1:0] w_rw_idx;
    logic [7:0]       w_rd_byte;

    assign w_in_ro  = ({1'b0, r_ptr} < 9'(N_RO));
    assign w_in_rw  = (r_ptr >= RW_BASE) && ({1'b0, r_ptr} < RW_END);
    assign w_ro_idx = r_ptr[RO_IW-1:0];
    assign w_rw_idx = RW_IW'(r_ptr - RW_BASE);

    always_comb begin
        w_rd_byte = '0;
        if (r_ptr == LOCK_ADDR)
            w_rd_byte = {7'b0, r_unlocked};
        else if (w_in_ro)
            w_rd_byte = r_snap[w_ro_idx];
        else if (w_in_rw)
            w_rd_byte = r_rw[w_rw_idx];
    end

    always_comb begin
        rw_data = '0;
        for (int unsigned j = 0; j < N_RW; j++)
            rw_data[8*j +: 8] = r_rw[j];
    end

    assign tx_data    = r_tx;
    assign stretch_on = r_load;
    assign commit     = r_commit;
    assign wr_err     = r_wr_err;
    assign unlocked   = r_unlocked;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_tx          <= '0;
            r_load        <= 1'b0;
            r_commit_pend <= 1'b0;
            r_commit      <= 1'b0;
            r_wr_err      <= 1'b0;
            r_unlocked    <= 1'b0;
            r_dirty       <= 1'b0;
            for (int unsigned i = 0; i < N_RO; i++)
                r_snap[i] <= '0;
            for (int unsigned j = 0; j < N_RW; j++) begin
                r_rw[j]     <= RW_INIT[8*j +: 8];
                r_shadow[j] <= RW_INIT[8*j +: 8];
            end
        end else begin
            r_commit      <= r_commit_pend;
            r_commit_pend <= 1'b0;
            r_wr_err      <= 1'b0;
            r_load        <= 1'b0;
            if (r_load)
                r_tx <= w_rd_byte;

            // STOP is handled before a coincident START so the commit is never lost.
            if (stop) begin
                r_state <= S_IDLE;
                if (r_dirty) begin
                    for (int unsigned j = 0; j < N_RW; j++)
                        r_rw[j] <= r_shadow[j];
                    r_commit_pend <= 1'b1;
                    r_dirty       <= 1'b0;
                end
            end

            if (start) begin
                if (r_w) begin
                    r_state <= S_RD;
                    r_load  <= 1'b1;
                    for (int unsigned i = 0; i < N_RO; i++)
                        r_snap[i] <= ro_data[8*i +: 8];
                end else begin
                    r_state <= S_PTR;
                end
            end else if (!stop) begin
                case (r_state)
                    S_PTR: if (data_vld) begin
                        r_ptr   <= rx_data;
                        r_state <= S_WR;
                    end
                    S_WR: if (data_vld) begin
                        r_ptr <= r_ptr + 8'd1;
                        if (r_ptr == LOCK_ADDR) begin
                            r_unlocked <= (rx_data == LOCK_KEY);
                        end else if (w_in_rw && r_unlocked) begin
                            r_shadow[w_rw_idx] <= rx_data;
                            r_dirty            <= 1'b1;
                        end else begin
                            r_wr_err <= 1'b1;
                        end
                    end
                    S_RD: if (data_vld) begin
                        r_ptr  <= r_ptr + 8'd1;
                        r_load <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_regbank.sv
// Self-checking bench for i2c_regbank: hand sequences for the multi-cycle cases plus a
// table of single-register write/readback vectors; read bytes are checked via a scoreboard queue.
module tb_i2c_regbank;
    localparam logic [255:0] TB_INIT = {16{16'hC35A}};

    logic         clk, rst, start, stop, data_vld, r_w;
    logic [7:0]   rx_data, tx_data;
    logic         stretch_on, commit, wr_err, unlocked;
    logic [127:0] ro_data;
    logic [255:0] rw_data;

    i2c_regbank #(
        .N_RO(16), .N_RW(32), .RW_BASE(8'h40), .LOCK_ADDR(8'hFF),
        .LOCK_KEY(8'hA5), .RW_INIT(TB_INIT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .data_vld(data_vld),
        .r_w(r_w), .rx_data(rx_data), .tx_data(tx_data), .stretch_on(stretch_on),
        .ro_data(ro_data), .rw_data(rw_data), .commit(commit), .wr_err(wr_err),
        .unlocked(unlocked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic [7:0] v;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [7:0] ptr;
        logic [7:0] wdata;
        logic [7:0] exp_err;
        logic [7:0] exp_commit;
        logic [7:0] exp_rd;
    } vec_t;
    vec_t vecs[9];

    int n_checks = 0;
    int n_pass   = 0;
    int n_commit = 0;
    int n_err    = 0;
    logic prev_st = 1'b0;

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    endtask

    task automatic chkw(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %064h expected %064h", nm, act, exp);
    endtask

    // Scoreboard: a read byte is due when stretch_on drops after its one-cycle pulse.
    always @(negedge clk) begin
        if (rst) begin
            prev_st = 1'b0;
        end else begin
            if (commit) n_commit++;
            if (wr_err) n_err++;
            if (prev_st) begin
                chk8("stretch_1cyc", 8'(stretch_on), 8'h00);
                if (!stretch_on) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_load: got %02h expected no load", tx_data);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk8(e.nm, tx_data, e.v);
                    end
                end
            end
            prev_st = stretch_on;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic rw);
        start = 1'b1; r_w = rw;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        data_vld = 1'b1; rx_data = b;
        tick();
        data_vld = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic push(input string nm, input logic [7:0] v);
        exp_t e;
        e.nm = nm; e.v = v;
        exp_q.push_back(e);
    endtask

    task automatic wait_q();
        for (int k = 0; k < 8 && exp_q.size() != 0; k++) tick();
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL read_timeout: got %0d pending bytes expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic rd_start(input string nm, input logic [7:0] v);
        push(nm, v);
        pulse_start(1'b1);
        wait_q();
    endtask

    task automatic rd_next(input string nm, input logic [7:0] v);
        push(nm, v);
        send(8'h00);
        wait_q();
    endtask

    task automatic write_seq(input logic [7:0] ptr, input logic [7:0] d);
        pulse_start(1'b0);
        send(ptr);
        send(d);
        pulse_stop();
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int c0, e0;
        rst = 1'b1; start = 1'b0; stop = 1'b0; data_vld = 1'b0; r_w = 1'b0; rx_data = '0;
        for (int i = 0; i < 16; i++) ro_data[8*i +: 8] = 8'(8'hE0 + i);

        vecs[0] = '{8'h40, 8'h99, 8'd0, 8'd1, 8'h99};
        vecs[1] = '{8'h5F, 8'h3C, 8'd0, 8'd1, 8'h3C};
        vecs[2] = '{8'h60, 8'h44, 8'd1, 8'd0, 8'h00};
        vecs[3] = '{8'h3F, 8'h55, 8'd1, 8'd0, 8'h00};
        vecs[4] = '{8'h0F, 8'h66, 8'd1, 8'd0, 8'hEF};
        vecs[5] = '{8'h10, 8'h12, 8'd1, 8'd0, 8'h00};
        vecs[6] = '{8'hFF, 8'h00, 8'd0, 8'd0, 8'h00};
        vecs[7] = '{8'h41, 8'h77, 8'd1, 8'd0, 8'hAB};
        vecs[8] = '{8'hFF, 8'hA5, 8'd0, 8'd0, 8'h01};

        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk8("rst_tx", tx_data, 8'h00);
        chk8("rst_stretch", 8'(stretch_on), 8'h00);
        chk8("rst_commit", 8'(commit), 8'h00);
        chk8("rst_wr_err", 8'(wr_err), 8'h00);
        chk8("rst_unlocked", 8'(unlocked), 8'h00);
        chkw("rst_rw_data", rw_data, TB_INIT);

        // Reset in the middle of an unlocked burst write
        write_seq(8'hFF, 8'hA5);
        chk8("t1_unlock", 8'(unlocked), 8'h01);
        c0 = n_commit;
        pulse_start(1'b0);
        send(8'h40); send(8'h01); send(8'h02); send(8'h03);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chkw("t1_rw_init", rw_data, TB_INIT);
        chk8("t1_locked", 8'(unlocked), 8'h00);
        chk8("t1_tx_zero", tx_data, 8'h00);
        pulse_stop();
        repeat (3) tick();
        chkw("t1_rw_after_stop", rw_data, TB_INIT);
        chk8("t1_no_commit", 8'(n_commit - c0), 8'h00);
        rd_start("t1_ptr_reset_rd", 8'hE0);
        pulse_stop();

        // Locked write is rejected
        c0 = n_commit; e0 = n_err;
        write_seq(8'h40, 8'h12);
        chk8("t2_wr_err", 8'(n_err - e0), 8'h01);
        chk8("t2_rw0", rw_data[7:0], 8'h5A);
        chk8("t2_no_commit", 8'(n_commit - c0), 8'h00);

        // Unlock, burst write, atomic commit on STOP
        write_seq(8'hFF, 8'hA5);
        c0 = n_commit;
        pulse_start(1'b0);
        send(8'h40); send(8'h11); send(8'h22); send(8'h33);
        tick();
        chkw("t3_rw_before_stop", 256'(rw_data[23:0]), 256'(24'h5AC35A));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chkw("t3_rw_at_stop", 256'(rw_data[23:0]), 256'(24'h332211));
        chk8("t3_commit_not_yet", 8'(commit), 8'h00);
        tick();
        chk8("t3_commit_pulse", 8'(commit), 8'h01);
        tick();
        chk8("t3_commit_end", 8'(commit), 8'h00);
        chk8("t3_one_commit", 8'(n_commit - c0), 8'h01);

        // Repeated start reads the committed value, not the shadow
        c0 = n_commit;
        pulse_start(1'b0);
        send(8'h41); send(8'hAB);
        pulse_start(1'b0);
        send(8'h41);
        rd_start("t4_rd_old", 8'h22);
        chk8("t4_rw_hold", rw_data[15:8], 8'h22);
        chk8("t4_no_commit_sr", 8'(n_commit - c0), 8'h00);
        pulse_stop();
        repeat (3) tick();
        chk8("t4_rw_new", rw_data[15:8], 8'hAB);
        chk8("t4_commit", 8'(n_commit - c0), 8'h01);

        foreach (vecs[i]) begin
            c0 = n_commit; e0 = n_err;
            write_seq(vecs[i].ptr, vecs[i].wdata);
            chk8($sformatf("vec%0d_err", i), 8'(n_err - e0), vecs[i].exp_err);
            chk8($sformatf("vec%0d_commit", i), 8'(n_commit - c0), vecs[i].exp_commit);
            pulse_start(1'b0);
            send(vecs[i].ptr);
            rd_start($sformatf("vec%0d_rd", i), vecs[i].exp_rd);
            pulse_stop();
            tick();
        end

        // Snapshot coherency across a two-byte read
        ro_data[15:0] = 16'h01FF;
        pulse_start(1'b0);
        send(8'h00);
        push("t5_rd0", 8'hFF);
        pulse_start(1'b1);
        chk8("t5_stretch_start", 8'(stretch_on), 8'h01);
        tick();
        chk8("t5_stretch_drop0", 8'(stretch_on), 8'h00);
        wait_q();
        ro_data[15:0] = 16'h0200;
        push("t5_rd1", 8'h01);
        send(8'h00);
        chk8("t5_stretch_vld", 8'(stretch_on), 8'h01);
        tick();
        chk8("t5_stretch_drop1", 8'(stretch_on), 8'h00);
        wait_q();
        pulse_stop();

        // Pointer wrap, pointer persistence, unmapped write
        ro_data[7:0] = 8'h77;
        pulse_start(1'b0);
        send(8'hFF);
        rd_start("t6_rd_lock", 8'h01);
        rd_next("t6_rd_wrap", 8'h77);
        pulse_stop();
        tick();
        rd_start("t6_ptr_persist", 8'h77);
        pulse_stop();
        c0 = n_commit; e0 = n_err;
        write_seq(8'h20, 8'h00);
        chk8("t6_unmapped_err", 8'(n_err - e0), 8'h01);
        chk8("t6_unmapped_nocommit", 8'(n_commit - c0), 8'h00);

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
